// File: rtl/lif_aer_pkg.sv
// Shared types and helpers for the spike-to-AER encoder slice.
package lif_aer_pkg;

  localparam int DEFAULT_TIME_BITS = 8;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Address width that stays legal for degenerate neuron counts.
  function automatic int addr_width(input int n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/lsb_priority_encoder.sv
// Combinational lowest-set-bit encoder: index, any-set and exactly-one-set flags.
module lsb_priority_encoder
  import lif_aer_pkg::*;
#(
  parameter int NEURONS   = 8,
  parameter int ADDR_BITS = addr_width(NEURONS)
) (
  input  logic [NEURONS-1:0]   vec,
  output logic [ADDR_BITS-1:0] idx,
  output logic                 any,
  output logic                 onehot
);

  localparam logic [NEURONS-1:0] ONE = {{(NEURONS-1){1'b0}}, 1'b1};

  // Scan high to low so the lowest set bit wins.
  always_comb begin
    idx = '0;
    for (int i = NEURONS - 1; i >= 0; i--) begin
      if (vec[i]) idx = ADDR_BITS'(i);
    end
  end

  assign any    = |vec;
  assign onehot = any && ((vec & (vec - ONE)) == '0);

endmodule

// File: rtl/spike_aer_encoder.sv
// Captures one spike vector per timestep and drains its set bits as AER events, lowest index first.
// Optional empty-timestep marker event enabled by defining AER_EMPTY_MARKER_EN.
module spike_aer_encoder
  import lif_aer_pkg::*;
#(
  parameter int NEURONS   = 8,
  parameter int ADDR_BITS = addr_width(NEURONS),
  parameter int TIME_BITS = DEFAULT_TIME_BITS
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 spike_valid,
  input  logic [NEURONS-1:0]   spikes,
  output logic                 spike_ready,
  output logic                 ev_valid,
  input  logic                 ev_ready,
  output logic [ADDR_BITS-1:0] ev_addr,
  output logic [TIME_BITS-1:0] ev_time,
  output logic                 ev_last,
  output logic                 ev_empty,
  output logic                 overrun
);

  localparam logic [NEURONS-1:0] ONE = {{(NEURONS-1){1'b0}}, 1'b1};

`ifdef AER_EMPTY_MARKER_EN
  localparam bit EMPTY_MARKER = 1'b1;
`else
  localparam bit EMPTY_MARKER = 1'b0;
`endif

  state_t                 state;
  state_t                 state_next;
  logic [NEURONS-1:0]     pending;
  logic [TIME_BITS-1:0]   time_cnt;
  logic [TIME_BITS-1:0]   time_p0;
  logic                   overrun_r;
  logic                   empty_armed;
  logic [ADDR_BITS-1:0]   low_idx;
  logic                   pend_any;
  logic                   pend_onehot;
  logic                   handshake;
  logic                   accept;

  lsb_priority_encoder #(
    .NEURONS  (NEURONS),
    .ADDR_BITS(ADDR_BITS)
  ) u_lsb (
    .vec   (pending),
    .idx   (low_idx),
    .any   (pend_any),
    .onehot(pend_onehot)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next  = state;
    ev_valid    = (state == SEND) && (pend_any || empty_armed);
    ev_last     = ev_valid && (empty_armed || pend_onehot);
    handshake   = ev_valid && ev_ready;
    spike_ready = (state == IDLE) || (handshake && ev_last);
    accept      = spike_valid && spike_ready;
    if (accept) begin
      state_next = ((spikes != '0) || EMPTY_MARKER) ? SEND : IDLE;
    end else if (handshake && ev_last) begin
      state_next = IDLE;
    end
  end

  // Capture / drain stage: a new vector takes priority over clearing the drained bit,
  // since acceptance during SEND only happens on the final handshake.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending   <= '0;
      time_cnt  <= '0;
      time_p0   <= '0;
      overrun_r <= 1'b0;
    end else begin
      if (accept) begin
        pending  <= spikes;
        time_p0  <= time_cnt;
        time_cnt <= time_cnt + TIME_BITS'(1);
      end else if (handshake) begin
        pending <= pending & (pending - ONE);
      end
      if (spike_valid && !spike_ready) overrun_r <= 1'b1;
    end
  end

`ifdef AER_EMPTY_MARKER_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      empty_armed <= 1'b0;
    end else if (accept) begin
      empty_armed <= (spikes == '0);
    end else if (handshake && ev_last) begin
      empty_armed <= 1'b0;
    end
  end
`else
  assign empty_armed = 1'b0;
`endif

  assign ev_addr  = empty_armed ? '0 : low_idx;
  assign ev_time  = time_p0;
  assign ev_empty = ev_valid && empty_armed;
  assign overrun  = overrun_r;

endmodule

// File: tb/tb_spike_aer_encoder.sv
// Directed bench for spike_aer_encoder with an event-queue reference model and per-cycle compare.
module tb_spike_aer_encoder;

  localparam int N  = 8;
  localparam int AB = 3;
  localparam int TB = 8;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          spike_valid = 1'b0;
  logic [N-1:0]  spikes = '0;
  logic          spike_ready;
  logic          ev_valid;
  logic          ev_ready = 1'b0;
  logic [AB-1:0] ev_addr;
  logic [TB-1:0] ev_time;
  logic          ev_last;
  logic          ev_empty;
  logic          overrun;

  spike_aer_encoder #(.NEURONS(N), .ADDR_BITS(AB), .TIME_BITS(TB)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .spike_valid(spike_valid),
    .spikes     (spikes),
    .spike_ready(spike_ready),
    .ev_valid   (ev_valid),
    .ev_ready   (ev_ready),
    .ev_addr    (ev_addr),
    .ev_time    (ev_time),
    .ev_last    (ev_last),
    .ev_empty   (ev_empty),
    .overrun    (overrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int addr;
    int t;
    int last;
    int empty;
  } ev_t;

  ev_t q[$];     // model: events still owed to downstream
  ev_t obs[$];   // events the DUT actually handed over
  int  m_time;
  int  m_over;
`ifdef AER_EMPTY_MARKER_EN
  localparam bit MARK = 1'b1;
`else
  localparam bit MARK = 1'b0;
`endif

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
  endtask

  // Reference model: events expanded from each accepted vector, popped on handshake.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q.delete();
      m_time = 0;
      m_over = 0;
    end else begin
      automatic bit rdy = (q.size() == 0) || (ev_ready && q.size() == 1);
      if (q.size() > 0 && ev_ready) void'(q.pop_front());
      if (spike_valid) begin
        if (rdy) begin
          automatic int cnt = $countones(spikes);
          automatic int k = 0;
          for (int i = 0; i < N; i++) begin
            if (spikes[i]) begin
              k++;
              q.push_back('{addr: i, t: m_time, last: (k == cnt) ? 1 : 0, empty: 0});
            end
          end
          if (cnt == 0 && MARK) q.push_back('{addr: 0, t: m_time, last: 1, empty: 1});
          m_time = (m_time + 1) % 256;
        end else begin
          m_over = 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      check("spike_ready", int'(spike_ready), (q.size() == 0 || (ev_ready && q.size() == 1)) ? 1 : 0);
      check("ev_valid", int'(ev_valid), (q.size() > 0) ? 1 : 0);
      check("overrun", int'(overrun), m_over);
      if (q.size() > 0) begin
        check("ev_addr", int'(ev_addr), q[0].addr);
        check("ev_time", int'(ev_time), q[0].t);
        check("ev_last", int'(ev_last), q[0].last);
        check("ev_empty", int'(ev_empty), q[0].empty);
      end else begin
        check("ev_empty_idle", int'(ev_empty), 0);
      end
      if (ev_valid && ev_ready)
        obs.push_back('{addr: int'(ev_addr), t: int'(ev_time), last: int'(ev_last), empty: int'(ev_empty)});
    end
  end

  task automatic step(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic drive(input bit v, input logic [N-1:0] s);
    spike_valid = v;
    spikes = s;
    step(1);
    spike_valid = 1'b0;
  endtask

  task automatic check_obs(input string name, input int idx, input int addr, input int t,
                           input int last, input int empty);
    if (idx >= obs.size()) begin
      check({name, "_present"}, obs.size(), idx + 1);
    end else begin
      check({name, "_addr"}, obs[idx].addr, addr);
      check({name, "_time"}, obs[idx].t, t);
      check({name, "_last"}, obs[idx].last, last);
      check({name, "_empty"}, obs[idx].empty, empty);
    end
  endtask

  initial begin
    #2;
    check("rst_ev_valid", int'(ev_valid), 0);
    check("rst_spike_ready", int'(spike_ready), 1);
    check("rst_overrun", int'(overrun), 0);
    step(2);
    rst_n = 1'b1;
    step(1);

    // Test 1: A4 drained at full rate.
    obs.delete();
    ev_ready = 1'b1;
    drive(1'b1, 8'b1010_0100);
    step(5);
    check("t1_count", obs.size(), 3);
    check_obs("t1_e0", 0, 2, 0, 0, 0);
    check_obs("t1_e1", 1, 5, 0, 0, 0);
    check_obs("t1_e2", 2, 7, 0, 1, 0);

    // Test 2: same vector with ready toggling.
    obs.delete();
    spike_valid = 1'b1;
    spikes = 8'b1010_0100;
    for (int i = 0; i < 12; i++) begin
      ev_ready = i[0];
      step(1);
      spike_valid = 1'b0;
    end
    ev_ready = 1'b1;
    step(2);
    check("t2_count", obs.size(), 3);
    check_obs("t2_e0", 0, 2, 1, 0, 0);
    check_obs("t2_e1", 1, 5, 1, 0, 0);
    check_obs("t2_e2", 2, 7, 1, 1, 0);

    // Test 3: overrun drop, then accept on the final handshake.
    obs.delete();
    drive(1'b1, 8'h03);
    drive(1'b1, 8'h01);
    drive(1'b1, 8'h80);
    step(3);
    check("t3_overrun", int'(overrun), 1);
    check("t3_count", obs.size(), 3);
    check_obs("t3_e0", 0, 0, 2, 0, 0);
    check_obs("t3_e1", 1, 1, 2, 1, 0);
    check_obs("t3_e2", 2, 7, 3, 1, 0);

    // Test 4: all-zero vector.
    obs.delete();
    drive(1'b1, 8'h00);
    step(2);
    drive(1'b1, 8'h01);
    step(3);
`ifdef AER_EMPTY_MARKER_EN
    check("t4_count", obs.size(), 2);
    check_obs("t4_mark", 0, 0, 4, 1, 1);
    check_obs("t4_next", 1, 0, 5, 1, 0);
`else
    check("t4_count", obs.size(), 1);
    check_obs("t4_next", 0, 0, 5, 1, 0);
`endif

    // Test 5: 260 back-to-back vectors, time counter wraps.
    obs.delete();
    spike_valid = 1'b1;
    spikes = 8'h01;
    step(260);
    spike_valid = 1'b0;
    step(3);
    check("t5_count", obs.size(), 260);
    begin
      automatic int wraps = 0;
      for (int i = 1; i < obs.size(); i++)
        if (obs[i-1].t == 255 && obs[i].t == 0) wraps++;
      check("t5_wrap", wraps, 1);
    end
    check_obs("t5_first", 0, 0, 6, 1, 0);
    check_obs("t5_lastev", 259, 0, 9, 1, 0);

    // Test 6: reset in the middle of an FF drain.
    ev_ready = 1'b0;
    drive(1'b1, 8'hFF);
    drive(1'b1, 8'h10);
    step(1);
    ev_ready = 1'b1;
    step(2);
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_valid", int'(ev_valid), 0);
    check("t6_ready", int'(spike_ready), 1);
    check("t6_overrun", int'(overrun), 0);
    step(2);
    rst_n = 1'b1;
    obs.delete();
    step(3);
    check("t6_quiet", obs.size(), 0);
    drive(1'b1, 8'h02);
    step(3);
    check("t6_count", obs.size(), 1);
    check_obs("t6_e0", 0, 1, 0, 1, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
